// File: rtl/mem_16nm_bist_pkg.sv
// Shared types and limits for the 16nm memory BIST response checker.
// Pure declarations: no logic, no latency, no flow control.
// Imported by the checker top and its delay pipe.
package mem_16nm_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 4;
    localparam int ERR_W_DEF  = 8;

endpackage

// File: rtl/mem_16nm_bist_dly.sv
// Fixed-depth {valid, addr, data} shift pipe aligning issued accesses with read data.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; shifts every cycle, sync clear empties all stages.
module mem_16nm_bist_dly #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_dat
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } ent_t;

    ent_t pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: in_vld, addr: in_addr, dat: in_dat};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out_vld  = pipe[DEPTH-1].vld;
    assign out_addr = pipe[DEPTH-1].addr;
    assign out_dat  = pipe[DEPTH-1].dat;

endmodule

// File: rtl/mem_16nm_bist_chk.sv
// BIST response checker: compares memory read data against delayed expected data, keeps pass/fail results.
// Latency: issue at t, compare at t+RD_LAT, status visible at t+RD_LAT+1.
// Backpressure: none; observes the controller only and never stalls it.
module mem_16nm_bist_chk
    import mem_16nm_bist_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic              bist_clk,
    input  logic              bist_reset,
    input  logic              bist_on,
    input  logic              bist_en,
    input  logic [ADDR_W-1:0] bist_addr,
    input  logic [DATA_W-1:0] bist_exp_data,
    input  logic [DATA_W-1:0] bist_rd_data,
    output logic              chk_busy,
    output logic              chk_done,
    output logic              chk_fail,
    output logic [ERR_W-1:0]  chk_err_cnt,
    output logic [ADDR_W-1:0] chk_fail_addr,
    output logic [DATA_W-1:0] chk_fail_bits
);

    localparam int CNT_W = $clog2(MAX_RD_LAT + 1);

    generate
        if (RD_LAT < MIN_RD_LAT || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
            $error("mem_16nm_bist_chk: RD_LAT out of range");
        end
    endgenerate

    chk_state_t        state, state_nxt;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic              bist_on_q;
    logic              start, start_clr;
    logic              pipe_vld;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_exp;
    logic [DATA_W-1:0] diff;
    logic              miscmp;

    assign start     = bist_on & ~bist_on_q;
    assign start_clr = start & ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN: begin
                if (!bist_on) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = CNT_W'(RD_LAT);
                end
            end
            DRAIN: begin
                // Extra cycle past the last compare lets its result register before DONE.
                if (drain_cnt == '0) state_nxt = DONE;
                else                 drain_cnt_nxt = drain_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bist_clk or posedge bist_reset) begin
        if (bist_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            bist_on_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            bist_on_q <= bist_on;
        end
    end

    mem_16nm_bist_dly #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (RD_LAT)
    ) u_dly (
        .clk      (bist_clk),
        .rst      (bist_reset),
        .clr      (start_clr),
        .in_vld   (bist_en & (state == RUN)),
        .in_addr  (bist_addr),
        .in_dat   (bist_exp_data),
        .out_vld  (pipe_vld),
        .out_addr (pipe_addr),
        .out_dat  (pipe_exp)
    );

    assign diff   = bist_rd_data ^ pipe_exp;
    assign miscmp = pipe_vld & ((state == RUN) || (state == DRAIN)) & (|diff);

    always_ff @(posedge bist_clk or posedge bist_reset) begin
        if (bist_reset) begin
            chk_fail      <= 1'b0;
            chk_err_cnt   <= '0;
            chk_fail_addr <= '0;
            chk_fail_bits <= '0;
        end else if (start_clr) begin
            chk_fail      <= 1'b0;
            chk_err_cnt   <= '0;
            chk_fail_addr <= '0;
            chk_fail_bits <= '0;
        end else if (miscmp) begin
            chk_fail <= 1'b1;
            if (chk_err_cnt != '1) chk_err_cnt <= chk_err_cnt + 1'b1;
            if (!chk_fail) begin
                chk_fail_addr <= pipe_addr;
                chk_fail_bits <= diff;
            end
        end
    end

    assign chk_busy = (state == RUN) || (state == DRAIN);
    assign chk_done = (state == DONE);

endmodule

// File: tb/tb_mem_16nm_bist_chk.sv
// Bench for mem_16nm_bist_chk: instance A (RD_LAT=1, ERR_W=8) and B (RD_LAT=3, ERR_W=4), bench acts as memory.
// Directed table of runs, hand sequences for restart/drain/reset, then random runs against a run-level model.
module tb_mem_16nm_bist_chk;

    logic bist_clk = 1'b0;
    logic bist_reset;
    always #5 bist_clk = ~bist_clk;

    logic        a_on, a_en, b_on, b_en;
    logic [2:0]  a_addr, b_addr;
    logic [63:0] a_exp, a_rd, b_exp, b_rd;
    logic        a_busy, a_done, a_fail, b_busy, b_done, b_fail;
    logic [7:0]  a_cnt;
    logic [3:0]  b_cnt;
    logic [2:0]  a_faddr, b_faddr;
    logic [63:0] a_fbits, b_fbits;

    mem_16nm_bist_chk #(.DATA_W(64), .ADDR_W(3), .RD_LAT(1), .ERR_W(8)) u_a (
        .bist_clk(bist_clk), .bist_reset(bist_reset), .bist_on(a_on), .bist_en(a_en),
        .bist_addr(a_addr), .bist_exp_data(a_exp), .bist_rd_data(a_rd),
        .chk_busy(a_busy), .chk_done(a_done), .chk_fail(a_fail), .chk_err_cnt(a_cnt),
        .chk_fail_addr(a_faddr), .chk_fail_bits(a_fbits));

    mem_16nm_bist_chk #(.DATA_W(64), .ADDR_W(3), .RD_LAT(3), .ERR_W(4)) u_b (
        .bist_clk(bist_clk), .bist_reset(bist_reset), .bist_on(b_on), .bist_en(b_en),
        .bist_addr(b_addr), .bist_exp_data(b_exp), .bist_rd_data(b_rd),
        .chk_busy(b_busy), .chk_done(b_done), .chk_fail(b_fail), .chk_err_cnt(b_cnt),
        .chk_fail_addr(b_faddr), .chk_fail_bits(b_fbits));

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        fail;
        logic [7:0]  cnt;
        logic [2:0]  faddr;
        logic [63:0] fbits;
    } obs_t;

    typedef struct {
        int          sel;
        int          n;
        bit          drop;
        bit          pulse;
        int          f0;
        logic [63:0] m0;
        int          f1;
        logic [63:0] m1;
        bit          fall;
        logic        ef;
        logic [7:0]  ecnt;
        logic [2:0]  eaddr;
        logic [63:0] ebits;
    } vec_t;

    int errs   = 0;
    int checks = 0;

    // One run's access list: access k is issued in run cycle k+1.
    logic        v_en   [64];
    logic [2:0]  v_addr [64];
    logic [63:0] v_exp  [64];
    logic [63:0] v_xor  [64];
    int          v_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic obs_t snap(input int sel);
        obs_t o;
        if (sel == 0) o = '{a_busy, a_done, a_fail, a_cnt, a_faddr, a_fbits};
        else          o = '{b_busy, b_done, b_fail, {4'b0, b_cnt}, b_faddr, b_fbits};
        return o;
    endfunction

    task automatic drive(input int sel, input logic on, input logic en, input logic [2:0] addr,
                         input logic [63:0] exp, input logic [63:0] rd);
        if (sel == 0) begin
            a_on = on; a_en = en; a_addr = addr; a_exp = exp; a_rd = rd;
        end else begin
            b_on = on; b_en = en; b_addr = addr; b_exp = exp; b_rd = rd;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drives one complete run from the access list and checks the held results once DONE appears.
    task automatic run_and_check(input string tag, input int sel, input bit drop, input bit pulse,
                                 input logic ef, input logic [7:0] ecnt, input logic [2:0] eaddr,
                                 input logic [63:0] ebits);
        int   lat, k;
        bit   seen_done;
        obs_t o;
        logic on, en;
        logic [2:0]  ad;
        logic [63:0] ex, rd;
        lat = (sel == 0) ? 1 : 3;
        seen_done = 0;
        for (int c = 0; c <= v_n + 60 && !seen_done; c++) begin
            @(negedge bist_clk);
            o = snap(sel);
            if (drop && c == v_n + lat) check({tag, " busy in drain"}, 64'(o.busy), 64'd1);
            if (c > v_n && o.done) begin
                seen_done = 1;
            end else begin
                if (c == 0)          on = 1'b1;
                else if (c <= v_n)   on = !(drop && c == v_n);
                else                 on = pulse && (c == v_n + 1);
                if (c >= 1 && c <= v_n) begin
                    en = v_en[c-1]; ad = v_addr[c-1]; ex = v_exp[c-1];
                end else begin
                    en = 1'b0; ad = 3'($urandom); ex = rnd64();
                end
                k = c - lat;
                if (k >= 1 && k <= v_n && v_en[k-1]) rd = v_exp[k-1] ^ v_xor[k-1];
                else                                  rd = rnd64();
                drive(sel, on, en, ad, ex, rd);
            end
        end
        drive(sel, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        check({tag, " done reached"}, 64'(seen_done), 64'd1);
        o = snap(sel);
        check({tag, " busy"},  64'(o.busy),  64'd0);
        check({tag, " fail"},  64'(o.fail),  64'(ef));
        check({tag, " cnt"},   64'(o.cnt),   64'(ecnt));
        check({tag, " faddr"}, 64'(o.faddr), 64'(eaddr));
        check({tag, " fbits"}, o.fbits, ebits);
    endtask

    vec_t vt [7];

    initial begin
        obs_t        o;
        int          nerr, sel, maxv, tries;
        bit          drop, first, got;
        logic        m_fail;
        logic [2:0]  m_addr;
        logic [63:0] m_bits;

        vt[0] = '{0,  8, 0, 0, -1, 64'h0,                   -1, 64'h0,    0, 1'b0, 8'd0,  3'd0, 64'h0};
        vt[1] = '{0,  8, 0, 0,  5, 64'h10,                  -1, 64'h0,    0, 1'b1, 8'd1,  3'd5, 64'h10};
        vt[2] = '{0,  8, 0, 0,  2, 64'h1,                    6, 64'hFF00, 0, 1'b1, 8'd2,  3'd2, 64'h1};
        vt[3] = '{1, 20, 0, 0, -1, 64'h8000_0000_0000_0000, -1, 64'h0,    1, 1'b1, 8'd15, 3'd0, 64'h8000_0000_0000_0000};
        vt[4] = '{1,  8, 1, 1,  7, 64'h4,                   -1, 64'h0,    0, 1'b1, 8'd1,  3'd7, 64'h4};
        vt[5] = '{0, 12, 0, 0, 10, 64'hF0,                  -1, 64'h0,    0, 1'b1, 8'd1,  3'd2, 64'hF0};
        vt[6] = '{1,  6, 1, 0, -1, 64'h0,                   -1, 64'h0,    0, 1'b0, 8'd0,  3'd0, 64'h0};

        bist_reset = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #2 bist_reset = 1'b1;
        #3;
        o = snap(0);
        check("reset busy",  64'(o.busy),  64'd0);
        check("reset done",  64'(o.done),  64'd0);
        check("reset fail",  64'(o.fail),  64'd0);
        check("reset cnt",   64'(o.cnt),   64'd0);
        check("reset faddr", 64'(o.faddr), 64'd0);
        check("reset fbits", o.fbits,      64'd0);
        @(negedge bist_clk);
        bist_reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            v_n = vt[i].n;
            for (int k = 0; k < v_n; k++) begin
                v_en[k]   = 1'b1;
                v_addr[k] = 3'(k);
                v_exp[k]  = {32'hC3A5_96F0, 32'(k) * 32'h0101_0101};
                if (vt[i].fall || k == vt[i].f0) v_xor[k] = vt[i].m0;
                else if (k == vt[i].f1)          v_xor[k] = vt[i].m1;
                else                             v_xor[k] = 64'd0;
            end
            run_and_check($sformatf("vec%0d", i), vt[i].sel, vt[i].drop, vt[i].pulse,
                          vt[i].ef, vt[i].ecnt, vt[i].eaddr, vt[i].ebits);
        end

        // Instance A sits in DONE with a failure from vec5; a new run request must clear it at once.
        @(negedge bist_clk);
        check("restart precond fail", 64'(a_fail), 64'd1);
        drive(0, 1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
        @(negedge bist_clk);
        o = snap(0);
        check("restart busy",  64'(o.busy),  64'd1);
        check("restart fail",  64'(o.fail),  64'd0);
        check("restart cnt",   64'(o.cnt),   64'd0);
        check("restart faddr", 64'(o.faddr), 64'd0);
        check("restart fbits", o.fbits,      64'd0);
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge bist_clk);
            got = a_done;
        end
        check("restart done reached", 64'(got), 64'd1);

        for (int r = 0; r < 24; r++) begin
            sel  = $urandom_range(0, 1);
            drop = $urandom_range(0, 1);
            v_n  = $urandom_range(1, 30);
            for (int k = 0; k < v_n; k++) begin
                v_en[k]   = ($urandom_range(0, 3) != 0);
                v_addr[k] = 3'($urandom);
                v_exp[k]  = rnd64();
                if ($urandom_range(0, 3) == 0)
                    v_xor[k] = ($urandom_range(0, 1) != 0) ? (64'd1 << $urandom_range(0, 63)) : (rnd64() | 64'd1);
                else
                    v_xor[k] = 64'd0;
            end
            // Run-level model: every issued access is checked once, in issue order.
            maxv = (sel == 0) ? 255 : 15;
            nerr = 0; first = 1; m_addr = '0; m_bits = '0;
            foreach (v_en[k]) begin
                if (k < v_n && v_en[k] && v_xor[k] != 64'd0) begin
                    if (first) begin
                        m_addr = v_addr[k];
                        m_bits = v_xor[k];
                        first  = 0;
                    end
                    nerr++;
                end
            end
            m_fail = (nerr > 0);
            if (nerr > maxv) nerr = maxv;
            run_and_check($sformatf("rnd%0d", r), sel, drop, drop && ($urandom_range(0, 1) != 0),
                          m_fail, 8'(nerr), m_addr, m_bits);
        end

        // Reset in the middle of a failing run on A: every output drops without a clock edge.
        @(negedge bist_clk);
        drive(0, 1'b1, 1'b0, 3'd0, 64'd0, 64'hFFFF);
        for (int c = 1; c <= 4; c++) begin
            @(negedge bist_clk);
            drive(0, 1'b1, 1'b1, 3'(c), 64'd0, 64'hFFFF);
        end
        @(negedge bist_clk);
        check("midrst precond fail", 64'(a_fail), 64'd1);
        #2 bist_reset = 1'b1;
        #1;
        o = snap(0);
        check("midrst busy",  64'(o.busy),  64'd0);
        check("midrst done",  64'(o.done),  64'd0);
        check("midrst fail",  64'(o.fail),  64'd0);
        check("midrst cnt",   64'(o.cnt),   64'd0);
        check("midrst faddr", 64'(o.faddr), 64'd0);
        check("midrst fbits", o.fbits,      64'd0);
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        @(negedge bist_clk);
        bist_reset = 1'b0;
        tries = 0;
        repeat (2) @(negedge bist_clk);
        check("midrst idle after release", 64'({a_busy, a_done}), 64'd0);
        if (tries != 0) errs++;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_16nm_bist_chk.md
Name: mem_16nm_bist_chk

Overview:
- Response checker directly downstream of the 16nm memory BIST controller; one instance per memory port.
- Taps the controller's issued enable/address/expected data and the memory's returned read data. Compares after a fixed read latency.
- Accumulates pass/fail, a saturating error count, and first-fail address/bit mask. Results are held for the SAP-1 status readout after the run ends.

Parameters:
- DATA_W, 64, read/expected data width
- ADDR_W, 3, address width; instances for ports 0/1 use 2
- RD_LAT, 1, cycles from bist_en issue to valid bist_rd_data (1..4)
- ERR_W, 8, error counter width

Ports:
- bist_clk  in  1  BIST clock; all state on rising edge
- bist_reset  in  1  asynchronous, active-high reset
- bist_on  in  1  run request, same signal that drives the controller
- bist_en  in  1  controller access strobe for this port
- bist_addr  in  ADDR_W  controller address issued with bist_en
- bist_exp_data  in  DATA_W  expected data; the controller's bist_wr_data for this port
- bist_rd_data  in  DATA_W  memory read data, valid RD_LAT cycles after bist_en
- chk_busy  out  1  high in RUN or DRAIN
- chk_done  out  1  high in DONE
- chk_fail  out  1  sticky: at least one miscompare this run
- chk_err_cnt  out  ERR_W  miscompare count, saturating
- chk_fail_addr  out  ADDR_W  address of first miscompare
- chk_fail_bits  out  DATA_W  XOR mask (rd ^ exp) of first miscompare

Behaviour:
- Async reset: state=IDLE, delay pipe cleared, every output 0, bist_on_q=0.
- start = bist_on & ~bist_on_q, where bist_on_q is registered bist_on. start is honoured only in IDLE or DONE. In RUN and DRAIN it is ignored.
- FSM:
  - IDLE --start--> RUN
  - RUN --~bist_on--> DRAIN. The drain counter is loaded with RD_LAT.
  - DRAIN counts down each cycle; at 0 --> DONE. The pipe is empty on exit.
  - DONE --start--> RUN.
- On the start cycle: clear chk_fail, chk_err_cnt, chk_fail_addr, chk_fail_bits, and the pipe.
- Delay pipe: RD_LAT-deep shift register of {valid, addr, exp}.
  - In RUN, the entry pushed is {bist_en, bist_addr, bist_exp_data}.
  - In DRAIN, the entry pushed is {0, x, x}.
  - The pipe shifts every cycle; it never stalls.
- Compare slot: pipe output valid=1 in RUN or DRAIN. There is no compare when valid=0; bist_en gaps are legal.
- Miscompare: bist_rd_data != pipe exp (full DATA_W equality).
  - Registered one cycle after the compare slot: chk_fail<=1; chk_err_cnt<=sat(cnt+1).
  - When cnt == all-ones it holds there and does not wrap.
- First-fail capture: only when chk_fail==0 and no miscompare is pending in the register stage. Later miscompares never overwrite chk_fail_addr/chk_fail_bits.
- chk_done asserts the cycle after the last compare result is registered. Results are stable in DONE until the next start.
- bist_on deasserting in the same cycle as a bist_en issue: that access is still checked, because the pipe entry is already pushed.
- The address in the pipe is copied as-is. If the controller's address wraps past 2^ADDR_W, the wrapped value is recorded.
- Async reset mid-run: everything is abandoned immediately. No partial results are retained.
- Latency: issue at cycle t; data is compared at t+RD_LAT; status is visible at t+RD_LAT+1.

Decomposition:
- Package mem_16nm_bist_pkg:
  - chk_state_t enum {IDLE, RUN, DRAIN, DONE}
  - MAX_RD_LAT=4
  - RD_LAT range-check constant
  - ERR_W default
- Sub-module mem_16nm_bist_dly: parameterised {valid, addr, data} shift pipe, RD_LAT deep, async reset. This pipe is reused by the controller-side wrappers.
- The FSM, compare, and capture stay in the top module.

Test Plan:
- Clean run, RD_LAT=1, ADDR_W=3: bist_on high 8 cycles with 8 accesses, memory returns exp on each. Required: chk_done after DRAIN, chk_fail=0, chk_err_cnt=0.
- Single fault: rd_data at addr 5 = exp ^ 64'h0000_0000_0000_0010. Required: chk_fail=1, chk_err_cnt=1, chk_fail_addr=5, chk_fail_bits=64'h10.
- Two faults, at addr 2 then addr 6. Required: chk_err_cnt=2, chk_fail_addr=2 (first retained), chk_fail_bits from addr 2.
- Saturation, ERR_W=4: 20 consecutive miscompares. Required: chk_err_cnt=4'hF holds, no wrap.
- Latency/drain, RD_LAT=3:
  - bist_on drops in the same cycle as the last bist_en; that access is compared 3 cycles later.
  - chk_busy stays high through DRAIN; chk_done follows.
  - A bist_on pulse inside DRAIN is ignored.
- Reset/restart:
  - Assert bist_reset mid-RUN. Required: all outputs 0 asynchronously.
  - After DONE with chk_fail=1, a new bist_on rising edge clears all results in the start cycle.
